// File: rtl/rx_deframer_if.sv
// Demodulator/host-facing signal bundle of the deframer: bit strobes and control in, frame data and status out.
// No flow control; bits are single-cycle strobes that are never stalled.
interface rx_deframer_if;
    logic       bit_valid;
    logic       bit_in;
    logic       rx_enable;
    logic       int_mask;
    logic       int_clear;
    logic [7:0] DATA_BYTE_0;
    logic [7:0] DATA_BYTE_1;
    logic       int_flag;
    logic       int_rx_host;
    logic       status_busy;
    logic       frame_error;
    logic       overrun;

    modport master (
        output bit_valid, bit_in, rx_enable, int_mask, int_clear,
        input  DATA_BYTE_0, DATA_BYTE_1, int_flag, int_rx_host, status_busy, frame_error, overrun
    );

    modport slave (
        input  bit_valid, bit_in, rx_enable, int_mask, int_clear,
        output DATA_BYTE_0, DATA_BYTE_1, int_flag, int_rx_host, status_busy, frame_error, overrun
    );
endinterface

// File: rtl/rx_deframer.sv
// Hunts for a sync byte in a serial bit stream, then captures a two-byte payload MSB first.
// Data and int_flag are visible the cycle after the last payload strobe; no backpressure, inter-bit gaps beyond GAP_TIMEOUT abort the frame.
module rx_deframer #(
    parameter logic [7:0]  SYNC_WORD   = 8'hA5,
    parameter logic [15:0] GAP_TIMEOUT = 16'd2048
) (
    input  logic         G_CLK_RX,
    input  logic         reset,
    rx_deframer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        BYTE0 = 3'd2,
        BYTE1 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  sync_sr;
    logic [7:0]  shift_sr;
    logic [7:0]  stage0;
    logic [2:0]  bit_cnt;
    logic [15:0] gap_cnt;
    logic [7:0]  data0_q;
    logic [7:0]  data1_q;
    logic        int_flag_q;
    logic        overrun_q;
    logic        frame_error_q;

    logic [7:0]  sync_next;
    logic [7:0]  shift_next;

    assign sync_next  = {sync_sr[6:0], bus.bit_in};
    assign shift_next = {shift_sr[6:0], bus.bit_in};

    assign bus.DATA_BYTE_0 = data0_q;
    assign bus.DATA_BYTE_1 = data1_q;
    assign bus.int_flag    = int_flag_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_error = frame_error_q;
    assign bus.int_rx_host = int_flag_q & ~bus.int_mask;
    assign bus.status_busy = (state == BYTE0) || (state == BYTE1);

    always_ff @(posedge G_CLK_RX) begin
        if (!reset) begin
            state         <= IDLE;
            sync_sr       <= 8'h00;
            shift_sr      <= 8'h00;
            stage0        <= 8'h00;
            bit_cnt       <= 3'd0;
            gap_cnt       <= 16'd0;
            data0_q       <= 8'h00;
            data1_q       <= 8'h00;
            int_flag_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            if (bus.int_clear) begin
                int_flag_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            // Disabling the receiver drops any partial frame but leaves published data and flags intact.
            if (!bus.rx_enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= HUNT;
                        sync_sr <= 8'h00;
                    end
                    HUNT: begin
                        if (bus.bit_valid) begin
                            sync_sr <= sync_next;
                            if (sync_next == SYNC_WORD) begin
                                state   <= BYTE0;
                                bit_cnt <= 3'd0;
                                gap_cnt <= 16'd0;
                            end
                        end
                    end
                    BYTE0, BYTE1: begin
                        // A strobe in the same cycle the gap limit is reached still counts.
                        if (bus.bit_valid) begin
                            shift_sr <= shift_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            gap_cnt  <= 16'd0;
                            if (bit_cnt == 3'd7) begin
                                if (state == BYTE0) begin
                                    stage0 <= shift_next;
                                    state  <= BYTE1;
                                end else begin
                                    data0_q    <= stage0;
                                    data1_q    <= shift_next;
                                    int_flag_q <= 1'b1;
                                    if (int_flag_q && !bus.int_clear) begin
                                        overrun_q <= 1'b1;
                                    end
                                    state <= DONE;
                                end
                            end
                        end else if (gap_cnt == GAP_TIMEOUT) begin
                            frame_error_q <= 1'b1;
                            state         <= HUNT;
                            sync_sr       <= 8'h00;
                        end else if (gap_cnt != 16'hFFFF) begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                    DONE: begin
                        state <= HUNT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: framing, sync hunt, gap timeout, overrun, masking, abort paths.
module tb_rx_deframer;

    logic G_CLK_RX = 1'b0;
    logic reset;

    always #5 G_CLK_RX = ~G_CLK_RX;

    rx_deframer_if bus ();

    rx_deframer #(
        .SYNC_WORD   (8'hA5),
        .GAP_TIMEOUT (16'd2048)
    ) dut (
        .G_CLK_RX (G_CLK_RX),
        .reset    (reset),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;

    always @(negedge G_CLK_RX) begin
        if (bus.frame_error === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits `idle` cycles, then presents one bit strobe; returns just after the sampling edge.
    task automatic send_bit(input int idle, input logic b);
        repeat (idle) @(posedge G_CLK_RX);
        #1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        @(posedge G_CLK_RX);
        #1;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(15, v[i]);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(8'hA5);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic clear_int();
        @(posedge G_CLK_RX);
        #1 bus.int_clear = 1'b1;
        @(posedge G_CLK_RX);
        #1 bus.int_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int         fe_before;
        int         n;
        bit         seen;

        reset         = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.rx_enable = 1'b0;
        bus.int_mask  = 1'b0;
        bus.int_clear = 1'b0;

        // Reset state
        repeat (3) @(posedge G_CLK_RX);
        @(negedge G_CLK_RX);
        chk("rst_d0", bus.DATA_BYTE_0, 8'h00);
        chk("rst_d1", bus.DATA_BYTE_1, 8'h00);
        chk("rst_flag", bus.int_flag, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);
        chk("rst_busy", bus.status_busy, 1'b0);
        chk("rst_fe", bus.frame_error, 1'b0);
        chk("rst_host", bus.int_rx_host, 1'b0);
        @(posedge G_CLK_RX);
        #1;
        reset         = 1'b1;
        bus.rx_enable = 1'b1;

        // Basic frame with mid-frame hold check
        send_byte(8'hA5);
        send_byte(8'h3C);
        v = 8'hC3;
        for (int i = 7; i >= 1; i--) send_bit(15, v[i]);
        @(negedge G_CLK_RX);
        chk("mid_busy", bus.status_busy, 1'b1);
        chk("mid_d0", bus.DATA_BYTE_0, 8'h00);
        chk("mid_flag", bus.int_flag, 1'b0);
        send_bit(15, v[0]);
        @(negedge G_CLK_RX);
        chk("f1_d0", bus.DATA_BYTE_0, 8'h3C);
        chk("f1_d1", bus.DATA_BYTE_1, 8'hC3);
        chk("f1_flag", bus.int_flag, 1'b1);
        chk("f1_host", bus.int_rx_host, 1'b1);
        chk("f1_busy", bus.status_busy, 1'b0);
        clear_int();
        @(negedge G_CLK_RX);
        chk("clr_flag", bus.int_flag, 1'b0);
        chk("clr_host", bus.int_rx_host, 1'b0);

        // Noise ahead of the sync byte
        fe_before = fe_cnt;
        send_bit(15, 1'b1);
        send_bit(15, 1'b0);
        send_bit(15, 1'b1);
        send_bit(15, 1'b1);
        send_frame(8'h12, 8'h34);
        @(negedge G_CLK_RX);
        chk("nz_d0", bus.DATA_BYTE_0, 8'h12);
        chk("nz_d1", bus.DATA_BYTE_1, 8'h34);
        chk("nz_fe", fe_cnt - fe_before, 0);
        chk("nz_ovr", bus.overrun, 1'b0);

        // Second frame without clearing -> overrun
        send_frame(8'h56, 8'h78);
        @(negedge G_CLK_RX);
        chk("ov_d0", bus.DATA_BYTE_0, 8'h56);
        chk("ov_d1", bus.DATA_BYTE_1, 8'h78);
        chk("ov_set", bus.overrun, 1'b1);
        clear_int();
        @(negedge G_CLK_RX);
        chk("ov_clr_flag", bus.int_flag, 1'b0);
        chk("ov_clr_ovr", bus.overrun, 1'b0);

        // Gap timeout: frame_error exactly GAP_TIMEOUT+2 sample points after the last strobe
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_bit(15, 1'b1);
        n    = 0;
        seen = 1'b0;
        for (int k = 1; k <= 3000 && !seen; k++) begin
            @(negedge G_CLK_RX);
            if (bus.frame_error === 1'b1) begin
                seen = 1'b1;
                n    = k;
            end
        end
        chk("to_delay", n, 2050);
        @(negedge G_CLK_RX);
        chk("to_pulse", bus.frame_error, 1'b0);
        chk("to_busy", bus.status_busy, 1'b0);
        chk("to_d0", bus.DATA_BYTE_0, 8'h56);
        chk("to_flag", bus.int_flag, 1'b0);
        send_frame(8'h55, 8'hAA);
        @(negedge G_CLK_RX);
        chk("to_next_d0", bus.DATA_BYTE_0, 8'h55);
        chk("to_next_d1", bus.DATA_BYTE_1, 8'hAA);
        clear_int();

        // Strobe arriving exactly at the gap limit is accepted
        fe_before = fe_cnt;
        send_byte(8'hA5);
        v = 8'h9E;
        for (int i = 7; i >= 0; i--) send_bit((i == 4) ? 2048 : 15, v[i]);
        send_byte(8'h21);
        @(negedge G_CLK_RX);
        chk("edge_fe", fe_cnt - fe_before, 0);
        chk("edge_d0", bus.DATA_BYTE_0, 8'h9E);
        chk("edge_d1", bus.DATA_BYTE_1, 8'h21);
        clear_int();

        // Masked interrupt
        bus.int_mask = 1'b1;
        send_frame(8'h11, 8'h22);
        @(negedge G_CLK_RX);
        chk("mask_flag", bus.int_flag, 1'b1);
        chk("mask_host", bus.int_rx_host, 1'b0);
        bus.int_mask = 1'b0;
        #1;
        chk("unmask_host", bus.int_rx_host, 1'b1);

        // int_clear coinciding with completion: set wins, no overrun
        send_byte(8'hA5);
        send_byte(8'h33);
        v = 8'h44;
        for (int i = 7; i >= 1; i--) send_bit(15, v[i]);
        repeat (15) @(posedge G_CLK_RX);
        #1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = v[0];
        bus.int_clear = 1'b1;
        @(posedge G_CLK_RX);
        #1;
        bus.bit_valid = 1'b0;
        bus.int_clear = 1'b0;
        @(negedge G_CLK_RX);
        chk("setwin_flag", bus.int_flag, 1'b1);
        chk("setwin_ovr", bus.overrun, 1'b0);
        chk("setwin_d1", bus.DATA_BYTE_1, 8'h44);
        clear_int();

        // rx_enable dropped during BYTE1
        send_byte(8'hA5);
        send_byte(8'h77);
        for (int i = 0; i < 3; i++) send_bit(15, 1'b1);
        bus.rx_enable = 1'b0;
        @(posedge G_CLK_RX);
        @(negedge G_CLK_RX);
        chk("dis_busy", bus.status_busy, 1'b0);
        chk("dis_d0", bus.DATA_BYTE_0, 8'h33);
        chk("dis_d1", bus.DATA_BYTE_1, 8'h44);
        chk("dis_flag", bus.int_flag, 1'b0);
        #1 bus.rx_enable = 1'b1;
        send_frame(8'h5A, 8'hC3);
        @(negedge G_CLK_RX);
        chk("reen_d0", bus.DATA_BYTE_0, 8'h5A);
        chk("reen_d1", bus.DATA_BYTE_1, 8'hC3);
        clear_int();

        // Reset during BYTE1
        send_byte(8'hA5);
        send_byte(8'h66);
        for (int i = 0; i < 4; i++) send_bit(15, 1'b0);
        reset = 1'b0;
        @(posedge G_CLK_RX);
        #1 reset = 1'b1;
        @(negedge G_CLK_RX);
        chk("rb_busy", bus.status_busy, 1'b0);
        chk("rb_d0", bus.DATA_BYTE_0, 8'h00);
        chk("rb_d1", bus.DATA_BYTE_1, 8'h00);
        send_frame(8'h9C, 8'h3A);
        @(negedge G_CLK_RX);
        chk("rb_next_d0", bus.DATA_BYTE_0, 8'h9C);
        chk("rb_next_d1", bus.DATA_BYTE_1, 8'h3A);
        chk("rb_next_flag", bus.int_flag, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
